// File: rtl/iob_target.sv
`default_nettype none
// ============================================================================
// Module   : iob_target
// Purpose  : 68000-bus target for the PDS/IOB side; 8-word register window
//            terminated by nDTACK, nVPA/E-clock transfer, or nBERR timeout.
//            Optional 6800 path compiled in with `define IOBT_VPA_EN.
// Revision : 1.0 - initial release
// ============================================================================
module iob_target #(
    parameter int WAIT_STATES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic        nAS,
    input  logic        RnW,
    input  logic        nUDS,
    input  logic        nLDS,
    input  logic        nVMA,
    input  logic        E,
    input  logic        SEL,
    input  logic        VPASEL,
    input  logic [2:0]  A,
    input  logic [15:0] D_in,
    output logic [15:0] D_out,
    output logic        DOE,
    output logic        nDTACK,
    output logic        nVPA,
    output logic        nBERR
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_WAIT  = 3'd1;
    localparam logic [2:0] c_ACK   = 3'd2;
`ifdef IOBT_VPA_EN
    localparam logic [2:0] c_VPA   = 3'd3;
    localparam logic [2:0] c_VMAW  = 3'd4;
    localparam logic [2:0] c_EWAIT = 3'd5;
`endif
    localparam logic [2:0] c_BERR  = 3'd6;
    localparam logic [2:0] c_DONE  = 3'd7;

    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  r_asSync, r_rnwSync, r_udsSync, r_ldsSync;
    logic        r_asPrev;
    logic [2:0]  r_state, w_next;
    logic [2:0]  r_wait;
    logic [7:0]  r_tmo;
    logic        r_rnw;
    logic [2:0]  r_addr;
    logic [15:0] r_regs [8];
    logic [15:0] r_dOut;
    logic        r_doe, r_nDtack, r_nVpa, r_nBerr;

    logic w_asf, w_asr, w_dsLow, w_tmoHit, w_tmoRun, w_commit;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_asSync  <= 2'b11;
            r_rnwSync <= 2'b11;
            r_udsSync <= 2'b11;
            r_ldsSync <= 2'b11;
            r_asPrev  <= 1'b1;
        end else begin
            r_asSync  <= {r_asSync[0], nAS};
            r_rnwSync <= {r_rnwSync[0], RnW};
            r_udsSync <= {r_udsSync[0], nUDS};
            r_ldsSync <= {r_ldsSync[0], nLDS};
            r_asPrev  <= r_asSync[1];
        end
    end

    assign w_asf    = r_asPrev & ~r_asSync[1];
    assign w_asr    = r_asSync[1];
    assign w_dsLow  = ~r_udsSync[1] | ~r_ldsSync[1];
    assign w_tmoHit = (r_tmo == c_TMO_LAST);

`ifdef IOBT_VPA_EN
    logic [1:0] r_vmaSync, r_eSync;
    logic       r_ePrev, r_eSeen;
    logic       w_eRise, w_eFall;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_vmaSync <= 2'b11;
            r_eSync   <= 2'b00;
            r_ePrev   <= 1'b0;
            r_eSeen   <= 1'b0;
        end else begin
            r_vmaSync <= {r_vmaSync[0], nVMA};
            r_eSync   <= {r_eSync[0], E};
            r_ePrev   <= r_eSync[1];
            // Only an E rise seen after nVMA qualifies the terminating high phase
            if (r_state != c_EWAIT)
                r_eSeen <= 1'b0;
            else if (w_eRise)
                r_eSeen <= 1'b1;
        end
    end

    assign w_eRise  = r_eSync[1] & ~r_ePrev;
    assign w_eFall  = ~r_eSync[1] & r_ePrev;
    assign w_tmoRun = (r_state == c_WAIT) || (r_state == c_VMAW) || (r_state == c_EWAIT);
`else
    logic w_unusedVpa;
    assign w_unusedVpa = &{1'b0, E, nVMA};
    assign w_tmoRun    = (r_state == c_WAIT);
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_asf) begin
                    if (!SEL)
                        w_next = c_DONE;
                    else if (VPASEL)
`ifdef IOBT_VPA_EN
                        w_next = c_VPA;
`else
                        w_next = c_BERR;
`endif
                    else
                        w_next = c_WAIT;
                end
            end
            c_WAIT: begin
                if (w_asr)                            w_next = c_IDLE;
                else if (w_tmoHit)                    w_next = c_BERR;
                else if ((r_wait == 3'd0) && w_dsLow) w_next = c_ACK;
            end
`ifdef IOBT_VPA_EN
            c_VPA: w_next = w_asr ? c_IDLE : c_VMAW;
            c_VMAW: begin
                if (w_asr)              w_next = c_IDLE;
                else if (w_tmoHit)      w_next = c_BERR;
                else if (!r_vmaSync[1]) w_next = c_EWAIT;
            end
            c_EWAIT: begin
                if (w_asr)                   w_next = c_IDLE;
                else if (w_tmoHit)           w_next = c_BERR;
                else if (r_eSeen && w_eFall) w_next = c_DONE;
            end
`endif
            c_ACK, c_BERR, c_DONE: begin
                if (w_asr) w_next = c_IDLE;
            end
            default: w_next = c_IDLE;
        endcase
    end

`ifdef IOBT_VPA_EN
    assign w_commit = ~r_rnw & (((r_state == c_WAIT) && (w_next == c_ACK)) ||
                                ((r_state == c_EWAIT) && (w_next == c_DONE)));
`else
    assign w_commit = ~r_rnw & (r_state == c_WAIT) && (w_next == c_ACK);
`endif

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_state <= c_IDLE;
            r_wait  <= 3'd0;
            r_tmo   <= 8'd0;
            r_rnw   <= 1'b1;
            r_addr  <= 3'd0;
        end else begin
            r_state <= w_next;
            if (r_state == c_IDLE) begin
                r_wait <= 3'(WAIT_STATES);
                r_tmo  <= 8'd0;
            end else begin
                if ((r_state == c_WAIT) && (r_wait != 3'd0))
                    r_wait <= r_wait - 3'd1;
                if (w_tmoRun)
                    r_tmo <= r_tmo + 8'd1;
            end
            if ((r_state == c_IDLE) && w_asf) begin
                r_rnw  <= r_rnwSync[1];
                r_addr <= A;
            end
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            for (int i = 0; i < 8; i++)
                r_regs[i] <= 16'h0000;
        end else if (w_commit) begin
            if (!r_udsSync[1]) r_regs[r_addr][15:8] <= D_in[15:8];
            if (!r_ldsSync[1]) r_regs[r_addr][7:0]  <= D_in[7:0];
        end
    end

    // Terminations are registered from the next state; DONE freezes them
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            r_nDtack <= 1'b1;
            r_nVpa   <= 1'b1;
            r_nBerr  <= 1'b1;
            r_doe    <= 1'b0;
            r_dOut   <= 16'h0000;
        end else if (w_next != c_DONE) begin
            r_nDtack <= 1'b1;
            r_nVpa   <= 1'b1;
            r_nBerr  <= 1'b1;
            case (w_next)
                c_ACK: begin
                    r_nDtack <= 1'b0;
                    if ((r_state != c_ACK) && r_rnw) begin
                        r_dOut <= r_regs[r_addr];
                        r_doe  <= 1'b1;
                    end
                end
`ifdef IOBT_VPA_EN
                c_VPA, c_VMAW: r_nVpa <= 1'b0;
                c_EWAIT: begin
                    r_nVpa <= 1'b0;
                    if ((r_state == c_VMAW) && r_rnw) begin
                        r_dOut <= r_regs[r_addr];
                        r_doe  <= 1'b1;
                    end
                end
`endif
                c_BERR: begin
                    r_nBerr <= 1'b0;
                    r_doe   <= 1'b0;
                    r_dOut  <= 16'h0000;
                end
                default: begin
                    r_doe  <= 1'b0;
                    r_dOut <= 16'h0000;
                end
            endcase
        end
    end

    assign D_out  = r_dOut;
    assign DOE    = r_doe;
    assign nDTACK = r_nDtack;
    assign nVPA   = r_nVpa;
    assign nBERR  = r_nBerr;

endmodule
`default_nettype wire

// File: doc/iob_target.md
# iob_target

Synchronous 68000-bus responder for the PDS/IOB side: the target end of the cycles the IOB master issues with nAS/RnW/nUDS/nLDS/nVMA. It decodes a selected cycle and terminates it with nDTACK (asynchronous-style path), nVPA plus an E-clock-synchronous transfer (6800-style path), or nBERR on timeout. It backs an 8-word register window, and serves both as a card-side peripheral and as the bus-functional responder in master-side benches.

## Interface
Parameters:
- WAIT_STATES, 2: CLK cycles inserted between cycle detection and nDTACK assertion (0–7).
- TIMEOUT, 255: CLK cycles a selected cycle may remain unterminated before nBERR (8-bit counter).

Ports:
- CLK  in  1  sole clock (16 MHz-class bus clock); all bus inputs are asynchronous to it.
- RES  in  1  asynchronous, active-high reset.
- nAS, RnW, nUDS, nLDS, nVMA  in  1 each  bus strobes from the master.
- E  in  1  6800 E clock.
- SEL  in  1  external address decode: cycle targets this block.
- VPASEL  in  1  selected cycle uses the 6800 path.
- A  in  3  word index A[3:1].
- D_in  in  16  write data.
- D_out  out  16  read data.
- DOE  out  1  read-data output enable.
- nDTACK, nVPA, nBERR  out  1 each  registered active-low terminations (open-drain at the pin, outside this block).

## Operation
- nAS, nUDS, nLDS, RnW, nVMA and E pass through 2-FF synchronizers. ASf is a one-cycle pulse on a synchronized nAS falling edge; ASr is high while synchronized nAS is high.
- Register file: 8 × 16-bit. Byte-lane writes: nUDS writes [15:8], nLDS writes [7:0]. Reset value 0.
- States: IDLE, WAIT, ACK, VPA, VMAW, EWAIT, BERR, DONE.
- IDLE: on ASf, sample SEL, VPASEL, RnW and A.
  - SEL=0 → DONE with no response.
  - SEL=1, VPASEL=0 → WAIT with the counter loaded to WAIT_STATES.
  - SEL=1, VPASEL=1 → VPA.
- WAIT: count down. At 0, go to ACK once at least one synchronized DS is low; otherwise keep waiting.
- ACK: assert nDTACK.
  - Read: D_out = reg[A], DOE=1.
  - Write: commit D_in on the enabled lanes on the entry cycle only.
  - Hold until ASr, then go to IDLE.
- VPA: assert nVPA, go to VMAW.
- VMAW: wait for synchronized nVMA low, then go to EWAIT. On a read, drive D_out/DOE from this point.
- EWAIT: wait for a synchronized E rise followed by a fall. On the fall, commit the write and go to DONE.
- DONE: hold current outputs until ASr, then go to IDLE.
- BERR: assert nBERR until ASr, then go to IDLE.
- The timeout counter runs in WAIT, VMAW and EWAIT and is cleared in IDLE. When it reaches TIMEOUT, go to BERR from any of these states, with no write commit.
- Abort: ASr in WAIT/VPA/VMAW/EWAIT returns to IDLE with no write, all outputs deasserted.
- Reset: state IDLE; nDTACK=nVPA=nBERR=1, DOE=0, D_out=0, counters 0, registers 0.

## Timing
- nAS fall to ASf: 2–3 CLK (synchronizer).
- ASf to nDTACK low: WAIT_STATES+2 CLK, if a DS is already low.
- Read data and DOE are valid on the same edge that asserts nDTACK.
- Synchronized nAS high to nDTACK/nVPA/nBERR high and DOE low: 1 CLK. All terminations are registered.
- 6800 path: nVPA asserts 1 CLK after ASf. Termination occurs on the first full E high phase that begins after nVMA is seen low.
- nDTACK, nVPA and nBERR are mutually exclusive in every cycle.
- ASf while not in IDLE is impossible by construction, since the block returns to IDLE only on ASr.

## Configuration
- IOBT_VPA_EN defined: the VPA, VMAW and EWAIT states and the E/nVMA synchronizers are compiled in, and VPASEL cycles take the 6800 path.
- IOBT_VPA_EN undefined: VPASEL=1 selected cycles go directly from IDLE to BERR (nBERR 1 CLK after ASf). The 6800-path logic is absent and E/nVMA are unused.

## Test plan
- Reset mid-ACK read: assert RES while nDTACK=0 → nDTACK=1, DOE=0, D_out=0 immediately; reg[0..7] all read back 0x0000.
- Word write then byte read, WAIT_STATES=2: write 0xA55A to A=3 with both DS low → nDTACK low 4 CLK after ASf. Then read with only nLDS low → D_out=0xA55A, DOE=1.
- Upper-byte-only write of 0x12FF to A=3 over 0xA55A → reg[3]=0x125A.
- 6800 read with IOBT_VPA_EN, reg[5]=0x00C3, VPASEL=1: nVPA low 1 CLK after ASf. After nVMA low and one E high/low period, D_out=0x00C3. nVPA releases 1 CLK after synchronized nAS rises.
- Timeout, TIMEOUT=16: selected cycle with DS held high → nBERR low 16 CLK after entering WAIT, no register change, nBERR high after nAS negates.
- Abort plus unselected cycle: nAS negated in WAIT → no termination, register unchanged. A cycle with SEL=0 produces no nDTACK/nVPA/nBERR, and the next selected cycle is served normally.
